// File: rtl/soc_pm_seq.sv
// Pixel-matrix control sequencer: shift-in, store pulse, gate window, strobe burst.
// Gate and strobe phases exist only when SOC_PM_SEQ_GATE_EN is defined.
module soc_pm_seq #(
  parameter int unsigned COLS  = 32,
  parameter int unsigned CNT_W = 16,
  parameter int unsigned DIV_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [COLS-1:0]  col_en,
  input  logic [CNT_W-1:0] shift_len,
  input  logic [DIV_W-1:0] clk_div,
  input  logic [DIV_W-1:0] store_len,
  input  logic [CNT_W-1:0] gate_len,
  input  logic [DIV_W-1:0] strobe_cnt,
  input  logic             data_valid,
  output logic             data_ready,
  input  logic [COLS-1:0]  data_a,
  input  logic [COLS-1:0]  data_b,
  output logic             busy,
  output logic             done,
  output logic [COLS-1:0]  store,
  output logic [COLS-1:0]  strobe,
  output logic [COLS-1:0]  gate,
  output logic [COLS-1:0]  sh_b,
  output logic [COLS-1:0]  sh_a,
  output logic [COLS-1:0]  clk_sh
);

`ifdef SOC_PM_SEQ_GATE_EN
  localparam bit GateEn = 1'b1;
`else
  localparam bit GateEn = 1'b0;
`endif

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [DIV_W-1:0] DIV_ONE = DIV_W'(1);

  typedef enum logic [3:0] {
    S_IDLE, S_LOAD, S_SETUP, S_CLK_HI, S_STORE, S_GATE, S_STB_HI, S_STB_LO, S_DONE
  } state_e;

  state_e           state_q, state_d;
  logic [CNT_W-1:0] tmr_q, tmr_d;
  logic [CNT_W-1:0] rem_q, rem_d;
  logic [CNT_W-1:0] gate_len_q, gate_len_d;
  logic [DIV_W-1:0] div_q, div_d;
  logic [DIV_W-1:0] store_len_q, store_len_d;
  logic [DIV_W-1:0] stb_q, stb_d;
  logic [COLS-1:0]  col_en_q, col_en_d;
  logic             start_ok;

  logic             busy_q, busy_d, done_q, done_d, rdy_q, rdy_d;
  logic [COLS-1:0]  store_q, store_d, strobe_q, strobe_d, gate_q, gate_d;
  logic [COLS-1:0]  sh_a_q, sh_a_d, sh_b_q, sh_b_d, clk_sh_q, clk_sh_d;

  assign start_ok = (state_q == S_IDLE) && start && !abort;

  // First non-empty phase among the ones still ahead of the caller.
  function automatic state_e phase_from(logic sh, logic st, logic gt, logic sb);
    if (sh)           return S_LOAD;
    if (st)           return S_STORE;
    if (GateEn && gt) return S_GATE;
    if (GateEn && sb) return S_STB_HI;
    return S_DONE;
  endfunction

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      tmr_q       <= '0;
      rem_q       <= '0;
      gate_len_q  <= '0;
      div_q       <= '0;
      store_len_q <= '0;
      stb_q       <= '0;
      col_en_q    <= '0;
    end else begin
      state_q     <= state_d;
      tmr_q       <= tmr_d;
      rem_q       <= rem_d;
      gate_len_q  <= gate_len_d;
      div_q       <= div_d;
      store_len_q <= store_len_d;
      stb_q       <= stb_d;
      col_en_q    <= col_en_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    tmr_d       = tmr_q;
    rem_d       = rem_q;
    stb_d       = stb_q;
    gate_len_d  = gate_len_q;
    div_d       = div_q;
    store_len_d = store_len_q;
    col_en_d    = col_en_q;

    if (start_ok) begin
      col_en_d    = col_en;
      div_d       = (clk_div == '0) ? DIV_ONE : clk_div;
      store_len_d = store_len;
      gate_len_d  = GateEn ? gate_len : '0;
      rem_d       = shift_len;
      stb_d       = GateEn ? strobe_cnt : '0;
    end

    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:
          if (start)
            state_d = phase_from(shift_len != '0, store_len != '0,
                                 gate_len != '0, strobe_cnt != '0);
        S_LOAD:   if (data_valid) state_d = S_SETUP;
        S_SETUP:  if (tmr_q == '0) state_d = S_CLK_HI;
        S_CLK_HI:
          if (tmr_q == '0) begin
            rem_d   = rem_q - CNT_ONE;
            state_d = (rem_q != CNT_ONE) ? S_LOAD
                    : phase_from(1'b0, store_len_q != '0, gate_len_q != '0, stb_q != '0);
          end
        S_STORE:
          if (tmr_q == '0)
            state_d = phase_from(1'b0, 1'b0, gate_len_q != '0, stb_q != '0);
        S_GATE:
          if (tmr_q == '0)
            state_d = phase_from(1'b0, 1'b0, 1'b0, stb_q != '0);
        S_STB_HI: if (tmr_q == '0) state_d = S_STB_LO;
        S_STB_LO:
          if (tmr_q == '0) begin
            stb_d   = stb_q - DIV_ONE;
            state_d = (stb_q != DIV_ONE) ? S_STB_HI : S_DONE;
          end
        S_DONE:   state_d = S_IDLE;
        default:  state_d = S_IDLE;
      endcase
    end

    // Every transition changes state, so a state change is where a phase timer reloads.
    if (state_d != state_q) begin
      case (state_d)
        S_SETUP, S_CLK_HI, S_STB_HI, S_STB_LO: tmr_d = CNT_W'(div_d) - CNT_ONE;
        S_STORE: tmr_d = CNT_W'(store_len_d) - CNT_ONE;
        S_GATE:  tmr_d = gate_len_d - CNT_ONE;
        default: tmr_d = '0;
      endcase
    end else if (tmr_q != '0) begin
      tmr_d = tmr_q - CNT_ONE;
    end
  end

  // Outputs are decoded from the next state and registered, so they line up with state_q.
  always_comb begin
    busy_d   = (state_d != S_IDLE);
    done_d   = (state_d == S_DONE);
    rdy_d    = (state_d == S_LOAD);
    store_d  = (state_d == S_STORE)  ? col_en_d : '0;
    clk_sh_d = (state_d == S_CLK_HI) ? col_en_d : '0;
`ifdef SOC_PM_SEQ_GATE_EN
    gate_d   = (state_d == S_GATE)   ? col_en_d : '0;
    strobe_d = (state_d == S_STB_HI) ? col_en_d : '0;
`else
    gate_d   = '0;
    strobe_d = '0;
`endif
    sh_a_d   = '0;
    sh_b_d   = '0;
    if (state_d inside {S_LOAD, S_SETUP, S_CLK_HI}) begin
      sh_a_d = sh_a_q;
      sh_b_d = sh_b_q;
      if (rdy_q && data_valid) begin
        sh_a_d = data_a & col_en_q;
        sh_b_d = data_b & col_en_q;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      rdy_q    <= 1'b0;
      store_q  <= '0;
      strobe_q <= '0;
      gate_q   <= '0;
      sh_a_q   <= '0;
      sh_b_q   <= '0;
      clk_sh_q <= '0;
    end else begin
      busy_q   <= busy_d;
      done_q   <= done_d;
      rdy_q    <= rdy_d;
      store_q  <= store_d;
      strobe_q <= strobe_d;
      gate_q   <= gate_d;
      sh_a_q   <= sh_a_d;
      sh_b_q   <= sh_b_d;
      clk_sh_q <= clk_sh_d;
    end
  end

  assign busy       = busy_q;
  assign done       = done_q;
  assign data_ready = rdy_q;
  assign store      = store_q;
  assign strobe     = strobe_q;
  assign gate       = gate_q;
  assign sh_a       = sh_a_q;
  assign sh_b       = sh_b_q;
  assign clk_sh     = clk_sh_q;

endmodule

// File: tb/tb_soc_pm_seq.sv
// Directed self-checking bench for soc_pm_seq; expectations follow SOC_PM_SEQ_GATE_EN.
module tb_soc_pm_seq;
  localparam int unsigned COLS  = 32;
  localparam int unsigned CNT_W = 16;
  localparam int unsigned DIV_W = 8;

  logic             clk = 1'b0, rst = 1'b1, start = 1'b0, abort = 1'b0, data_valid = 1'b0;
  logic [COLS-1:0]  col_en = '0, data_a = '0, data_b = '0;
  logic [CNT_W-1:0] shift_len = '0, gate_len = '0;
  logic [DIV_W-1:0] clk_div = '0, store_len = '0, strobe_cnt = '0;
  logic             data_ready, busy, done;
  logic [COLS-1:0]  store, strobe, gate, sh_b, sh_a, clk_sh;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  soc_pm_seq #(.COLS(COLS), .CNT_W(CNT_W), .DIV_W(DIV_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .col_en(col_en),
    .shift_len(shift_len), .clk_div(clk_div), .store_len(store_len),
    .gate_len(gate_len), .strobe_cnt(strobe_cnt), .data_valid(data_valid),
    .data_ready(data_ready), .data_a(data_a), .data_b(data_b), .busy(busy),
    .done(done), .store(store), .strobe(strobe), .gate(gate), .sh_b(sh_b),
    .sh_a(sh_a), .clk_sh(clk_sh)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %b, want %b", tag, obs, exp);
    end
  endtask

  task automatic chkv(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: got %08h, want %08h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk1({tag, "_busy"}, busy, 1'b0);
    chk1({tag, "_done"}, done, 1'b0);
    chk1({tag, "_rdy"}, data_ready, 1'b0);
    chkv({tag, "_buses"}, store | strobe | gate | sh_a | sh_b | clk_sh, 32'h0);
  endtask

  task automatic start_seq(input logic [31:0] ce, input logic [15:0] sl, input logic [7:0] dv,
                           input logic [7:0] sto, input logic [15:0] gl, input logic [7:0] sc);
    col_en = ce; shift_len = sl; clk_div = dv; store_len = sto; gate_len = gl; strobe_cnt = sc;
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  logic [31:0] w [3];
  logic [31:0] e_clk, e_sha, e_shb, e_sto, e_gate, e_stb;
  logic        e_rdy, e_done, e_busy;

  initial begin
    w[0] = 32'hA5A5_A5A5; w[1] = 32'h0F0F_0F0F; w[2] = 32'hFFFF_0000;

    // Reset state
    tick(); tick();
    chk_idle("rst_hold");
    rst = 1'b0;
    tick();
    chk_idle("rst_rel");

    // Basic shift: 3 steps of 5 cycles, DONE at cycle 16
    data_valid = 1'b1; data_a = w[0]; data_b = '0;
    start_seq(32'hFFFF_FFFF, 16'd3, 8'd2, 8'd0, 16'd0, 8'd0);
    for (int c = 1; c <= 17; c++) begin
      int k, p;
      k = (c - 1) / 5; p = (c - 1) % 5;
      e_rdy = 1'b0; e_clk = '0; e_sha = '0;
      if (c <= 15) begin
        e_rdy = (p == 0);
        e_clk = (p >= 3) ? 32'hFFFF_FFFF : 32'h0;
        if (p != 0)     e_sha = w[k];
        else if (k > 0) e_sha = w[k-1];
      end
      chk1($sformatf("shift_rdy_c%0d", c), data_ready, e_rdy);
      chkv($sformatf("shift_clk_c%0d", c), clk_sh, e_clk);
      chkv($sformatf("shift_sha_c%0d", c), sh_a, e_sha);
      chk1($sformatf("shift_done_c%0d", c), done, c == 16);
      chk1($sformatf("shift_busy_c%0d", c), busy, c <= 16);
      if (p == 0 && c <= 15) data_a = w[k];
      tick();
    end

    // Full sequence: store 4, gate 10, 3 strobes at div 1
    data_valid = 1'b0;
    start_seq(32'hFFFF_FFFF, 16'd0, 8'd1, 8'd4, 16'd10, 8'd3);
    for (int c = 1; c <= 22; c++) begin
      e_sto = (c <= 4) ? 32'hFFFF_FFFF : 32'h0;
`ifdef SOC_PM_SEQ_GATE_EN
      e_gate = (c >= 5 && c <= 14) ? 32'hFFFF_FFFF : 32'h0;
      e_stb  = (c >= 15 && c <= 20 && ((c - 15) % 2 == 0)) ? 32'hFFFF_FFFF : 32'h0;
      e_done = (c == 21);
      e_busy = (c <= 21);
`else
      e_gate = '0;
      e_stb  = '0;
      e_done = (c == 5);
      e_busy = (c <= 5);
`endif
      chkv($sformatf("full_store_c%0d", c), store, e_sto);
      chkv($sformatf("full_gate_c%0d", c), gate, e_gate);
      chkv($sformatf("full_strobe_c%0d", c), strobe, e_stb);
      chk1($sformatf("full_done_c%0d", c), done, e_done);
      chk1($sformatf("full_busy_c%0d", c), busy, e_busy);
      tick();
    end

    // Mask and stall: col_en 0xF0, valid low for cycles 4..8
    data_valid = 1'b1; data_a = 32'hFFFF_FFFF; data_b = 32'hA5A5_A5A5;
    start_seq(32'h0000_00F0, 16'd2, 8'd1, 8'd2, 16'd0, 8'd0);
    for (int c = 1; c <= 15; c++) begin
      e_rdy = (c == 1) || (c >= 4 && c <= 9);
      e_clk = (c == 3 || c == 11) ? 32'h0000_00F0 : 32'h0;
      e_sha = (c >= 2 && c <= 9) ? 32'h0000_00F0 : (c == 10 || c == 11) ? 32'h0000_0030 : 32'h0;
      e_shb = (c >= 2 && c <= 11) ? 32'h0000_00A0 : 32'h0;
      e_sto = (c == 12 || c == 13) ? 32'h0000_00F0 : 32'h0;
      chk1($sformatf("mask_rdy_c%0d", c), data_ready, e_rdy);
      chkv($sformatf("mask_clk_c%0d", c), clk_sh, e_clk);
      chkv($sformatf("mask_sha_c%0d", c), sh_a, e_sha);
      chkv($sformatf("mask_shb_c%0d", c), sh_b, e_shb);
      chkv($sformatf("mask_store_c%0d", c), store, e_sto);
      chk1($sformatf("mask_done_c%0d", c), done, c == 14);
      chkv($sformatf("mask_outside_c%0d", c),
           (store | strobe | gate | sh_a | sh_b | clk_sh) & 32'hFFFF_FF0F, 32'h0);
      if (c == 4) data_valid = 1'b0;
      if (c == 9) begin data_valid = 1'b1; data_a = 32'h0000_0F3C; end
      tick();
    end

    // Start while busy is ignored; latched store length and mask stay
    data_valid = 1'b0;
    start_seq(32'hFFFF_FFFF, 16'd0, 8'd3, 8'd8, 16'd10, 8'd0);
    tick();
    col_en = 32'h1; store_len = 8'd50; shift_len = 16'd5; start = 1'b1;
    tick();
    start = 1'b0;
    chkv("ign_store_c3", store, 32'hFFFF_FFFF);
    chk1("ign_rdy_c3", data_ready, 1'b0);
    chk1("ign_busy_c3", busy, 1'b1);
    repeat (5) tick();
    chkv("ign_store_c8", store, 32'hFFFF_FFFF);
    tick();
    chkv("ign_store_c9", store, 32'h0);
`ifdef SOC_PM_SEQ_GATE_EN
    chkv("ign_gate_c9", gate, 32'hFFFF_FFFF);
    tick();
    chkv("abort_gate_c10", gate, 32'hFFFF_FFFF);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_gate");
    for (int c = 0; c < 12; c++) begin
      chk1($sformatf("abort_gate_nodone_%0d", c), done, 1'b0);
      tick();
    end
`else
    chk1("ign_done_c9", done, 1'b1);
    tick();
    chk1("ign_busy_c10", busy, 1'b0);
`endif

    // Abort during STORE, then simultaneous start+abort in IDLE
    start_seq(32'hFFFF_FFFF, 16'd0, 8'd1, 8'd8, 16'd0, 8'd0);
    chkv("abort_sto_c1", store, 32'hFFFF_FFFF);
    tick(); tick();
    abort = 1'b1;
    tick();
    abort = 1'b0;
    chk_idle("abort_sto");
    for (int c = 0; c < 10; c++) begin
      chk1($sformatf("abort_sto_nodone_%0d", c), done | busy, 1'b0);
      tick();
    end
    start = 1'b1; abort = 1'b1;
    tick();
    start = 1'b0; abort = 1'b0;
    chk_idle("start_abort_1");
    tick();
    chk_idle("start_abort_2");

    // Asynchronous reset in the middle of CLK_HI
    data_valid = 1'b1; data_a = 32'hFFFF_FFFF; data_b = 32'hFFFF_FFFF;
    start_seq(32'hFFFF_FFFF, 16'd2, 8'd4, 8'd0, 16'd0, 8'd0);
    repeat (6) tick();
    chkv("rst_mid_clk", clk_sh, 32'hFFFF_FFFF);
    rst = 1'b1;
    #1;
    chk_idle("rst_async");
    tick();
    rst = 1'b0;
    data_valid = 1'b0;
    tick();
    chk_idle("rst_after");
    start_seq(32'h0000_FFFF, 16'd0, 8'd1, 8'd1, 16'd0, 8'd0);
    chkv("post_rst_store", store, 32'h0000_FFFF);
    chk1("post_rst_busy", busy, 1'b1);
    tick();
    chk1("post_rst_done", done, 1'b1);
    chkv("post_rst_store_off", store, 32'h0);
    tick();
    chk1("post_rst_idle", busy, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
